vertical_scale_controller: RTL and testbench

VERTICAL_SCALE_CONTROLLER -- requirements
Module: vertical_scale_controller

---
 rtl/vertical_scale_controller.sv | 155 +++++++++++++++
 tb/tb_vertical_scale_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vertical_scale_controller.sv
// Two-channel vertical scale controller: debounced up/down buttons step a
// one-hot x8 scale factor for the channel chosen by channelSelect.
module vertical_scale_controller #(
  parameter int SCALE_FACTOR_SIZE = 10,
  parameter int DEBOUNCE_CYCLES   = 1000000
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         buttonUp,
  input  logic                         buttonDown,
  input  logic                         channelSelect,
  output logic [SCALE_FACTOR_SIZE-1:0] verticalScaleFactorTimes8Channel1,
  output logic [SCALE_FACTOR_SIZE-1:0] verticalScaleFactorTimes8Channel2,
  output logic                         scaleChanged,
  output logic [3:0]                   o_dbg_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] L_TERM = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCALE_FACTOR_SIZE-1:0] L_UNITY = SCALE_FACTOR_SIZE'(8);
  localparam logic [SCALE_FACTOR_SIZE-1:0] L_MIN   = SCALE_FACTOR_SIZE'(1);
  localparam logic [SCALE_FACTOR_SIZE-1:0] L_MAX   = L_MIN << (SCALE_FACTOR_SIZE - 1);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } deb_state_t;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0] w_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_event;

  assign w_raw = {buttonDown, buttonUp};

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_deb
      deb_state_t    r_state;
      logic [CW-1:0] r_cnt;

      // The press event fires on the edge that completes the qualifying run,
      // so the factor register can take it on that same edge.
      assign w_event[g] = (r_state == ST_PRESS_WAIT) && r_sync2[g] && (r_cnt == L_TERM);

      always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
          r_state <= ST_RELEASED;
          r_cnt   <= '0;
        end else begin
          case (r_state)
            ST_RELEASED: begin
              if (r_sync2[g]) begin
                r_state <= ST_PRESS_WAIT;
                r_cnt   <= '0;
              end
            end
            ST_PRESS_WAIT: begin
              if (!r_sync2[g]) begin
                r_state <= ST_RELEASED;
                r_cnt   <= '0;
              end else if (r_cnt == L_TERM) begin
                r_state <= ST_PRESSED;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            ST_PRESSED: begin
              if (!r_sync2[g]) begin
                r_state <= ST_RELEASE_WAIT;
                r_cnt   <= '0;
              end
            end
            ST_RELEASE_WAIT: begin
              if (r_sync2[g]) begin
                r_state <= ST_PRESSED;
                r_cnt   <= '0;
              end else if (r_cnt == L_TERM) begin
                r_state <= ST_RELEASED;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            default: begin
              r_state <= ST_RELEASED;
              r_cnt   <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  assign o_dbg_state = {g_deb[1].r_state, g_deb[0].r_state};

  logic                         w_up;
  logic                         w_dn;
  logic [SCALE_FACTOR_SIZE-1:0] w_target;
  logic [SCALE_FACTOR_SIZE-1:0] w_next;
  logic                         w_change;
  logic [SCALE_FACTOR_SIZE-1:0] r_factor1;
  logic [SCALE_FACTOR_SIZE-1:0] r_factor2;
  logic                         r_changed;

  // Simultaneous up and down cancel each other out.
  assign w_up = w_event[0] & ~w_event[1];
  assign w_dn = w_event[1] & ~w_event[0];

  always_comb begin
    w_target = channelSelect ? r_factor2 : r_factor1;
    w_next   = w_target;
    w_change = 1'b0;
    if (w_up && (w_target != L_MAX)) begin
      w_next   = w_target << 1;
      w_change = 1'b1;
    end else if (w_dn && (w_target != L_MIN)) begin
      w_next   = w_target >> 1;
      w_change = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_factor1 <= L_UNITY;
      r_factor2 <= L_UNITY;
      r_changed <= 1'b0;
    end else begin
      r_changed <= w_change;
      if (w_change) begin
        if (channelSelect) r_factor2 <= w_next;
        else               r_factor1 <= w_next;
      end
    end
  end

  assign verticalScaleFactorTimes8Channel1 = r_factor1;
  assign verticalScaleFactorTimes8Channel2 = r_factor2;
  assign scaleChanged                      = r_changed;

endmodule

// File: tb/tb_vertical_scale_controller.sv
// Bench for vertical_scale_controller: table of clean presses, hand-written
// timing/reset sequences, and random button traffic against a run-length model.
module tb_vertical_scale_controller;

  localparam int W = 10;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         resetN = 1'b0;
  logic         buttonUp = 1'b0;
  logic         buttonDown = 1'b0;
  logic         channelSelect = 1'b0;
  logic [W-1:0] f1;
  logic [W-1:0] f2;
  logic         chg;
  logic [3:0]   dbg;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  always #5 clock = ~clock;

  vertical_scale_controller #(.SCALE_FACTOR_SIZE(W), .DEBOUNCE_CYCLES(D)) dut (
    .clock                            (clock),
    .resetN                           (resetN),
    .buttonUp                         (buttonUp),
    .buttonDown                       (buttonDown),
    .channelSelect                    (channelSelect),
    .verticalScaleFactorTimes8Channel1(f1),
    .verticalScaleFactorTimes8Channel2(f2),
    .scaleChanged                     (chg),
    .o_dbg_state                      (dbg)
  );

  // Reference model: raw buttons seen two edges late, a level flips after
  // D+1 consecutive opposite samples, factors tracked as exponents.
  logic mq_up[$];
  logic mq_dn[$];
  logic m_lvl_up, m_lvl_dn, m_chg;
  int   m_run_up, m_run_dn, m_e1, m_e2;

  function automatic logic [W-1:0] fac(input int e);
    logic [W-1:0] v;
    v = '0;
    v[e] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    mq_up = {1'b0, 1'b0};
    mq_dn = {1'b0, 1'b0};
    m_lvl_up = 1'b0; m_lvl_dn = 1'b0;
    m_run_up = 0;    m_run_dn = 0;
    m_e1 = 3;        m_e2 = 3;
    m_chg = 1'b0;
  endtask

  task automatic deb(input logic s, inout logic lvl, inout int run, output logic ev);
    ev = 1'b0;
    if (s != lvl) run++;
    else          run = 0;
    if (run == D + 1) begin
      lvl = s;
      run = 0;
      ev  = s;
    end
  endtask

  task automatic apply(inout int e, input logic up);
    if (up && e < W - 1) begin e++; m_chg = 1'b1; end
    else if (!up && e > 0) begin e--; m_chg = 1'b1; end
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic eu, ed;
    @(posedge clock);
    if (!resetN) begin
      model_reset();
    end else begin
      mq_up.push_back(buttonUp);
      mq_dn.push_back(buttonDown);
      deb(mq_up.pop_front(), m_lvl_up, m_run_up, eu);
      deb(mq_dn.pop_front(), m_lvl_dn, m_run_dn, ed);
      m_chg = 1'b0;
      if (eu ^ ed) begin
        if (channelSelect) apply(m_e2, eu);
        else               apply(m_e1, eu);
      end
    end
    #1;
    check("model_f1", f1, fac(m_e1));
    check("model_f2", f2, fac(m_e2));
    check("model_chg", W'(chg), W'(m_chg));
    if (chg) pulses++;
  endtask

  task automatic do_reset();
    buttonUp = 1'b0; buttonDown = 1'b0;
    resetN = 1'b0;
    model_reset();
    repeat (2) tick();
    resetN = 1'b1;
  endtask

  task automatic press(input logic up, input logic dn, input logic sel);
    channelSelect = sel;
    buttonUp = up; buttonDown = dn;
    repeat (10) tick();
    buttonUp = 1'b0; buttonDown = 1'b0;
    repeat (10) tick();
  endtask

  typedef struct {
    logic         up, dn, sel;
    logic [W-1:0] f1, f2;
    int           pulses;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 10'd16, 10'd8,  1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 10'd16, 10'd16, 1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 10'd8,  10'd16, 1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 10'd4,  10'd16, 1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 10'd2,  10'd16, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 10'd1,  10'd16, 1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 10'd1,  10'd16, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 10'd1,  10'd16, 0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 10'd1,  10'd32, 1};

    model_reset();
    tick();
    check("reset_f1", f1, 10'd8);
    check("reset_f2", f2, 10'd8);
    check("reset_chg", W'(chg), '0);
    do_reset();

    for (int i = 0; i < 9; i++) begin
      pulses = 0;
      press(tbl[i].up, tbl[i].dn, tbl[i].sel);
      check("tbl_f1", f1, tbl[i].f1);
      check("tbl_f2", f2, tbl[i].f2);
      check("tbl_pulses", W'(pulses), W'(tbl[i].pulses));
    end

    // Exact latency: change lands on the 7th edge after the raw rise.
    do_reset();
    channelSelect = 1'b0;
    buttonUp = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("lat_f1", f1, (k >= 7) ? 10'd16 : 10'd8);
      check("lat_chg", W'(chg), (k == 7) ? W'(1) : W'(0));
      check("lat_f2", f2, 10'd8);
    end
    buttonUp = 1'b0;
    repeat (10) tick();

    // Bouncing down button never qualifies.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      buttonDown = 1'b1; repeat (2) tick();
      buttonDown = 1'b0; repeat (2) tick();
    end
    repeat (10) tick();
    check("bounce_pulses", W'(pulses), '0);
    check("bounce_f1", f1, 10'd8);

    // Channel 2 climbs to the MSB and saturates.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      pulses = 0;
      press(1'b1, 1'b0, 1'b1);
      check("sat_f2", f2, fac((4 + i > 9) ? 9 : 4 + i));
      check("sat_pulses", W'(pulses), (i < 6) ? W'(1) : W'(0));
      check("sat_f1", f1, 10'd8);
    end

    // Simultaneous up and down cancel.
    do_reset();
    pulses = 0;
    press(1'b1, 1'b1, 1'b0);
    check("both_f1", f1, 10'd8);
    check("both_pulses", W'(pulses), '0);

    // Reset mid-debounce discards the pending press; held button re-debounces.
    do_reset();
    press(1'b1, 1'b0, 1'b0);
    channelSelect = 1'b0;
    buttonUp = 1'b1;
    repeat (4) tick();
    @(posedge clock);
    resetN = 1'b0;
    model_reset();
    #1;
    check("rst_f1", f1, 10'd8);
    check("rst_f2", f2, 10'd8);
    check("rst_chg", W'(chg), '0);
    repeat (2) tick();
    resetN = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("rst_lat_f1", f1, (k >= 7) ? 10'd16 : 10'd8);
      check("rst_lat_chg", W'(chg), (k == 7) ? W'(1) : W'(0));
    end
    buttonUp = 1'b0;
    repeat (10) tick();

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      buttonUp      = 1'($urandom_range(0, 1));
      buttonDown    = 1'($urandom_range(0, 1));
      channelSelect = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 14)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
